// File: rtl/usbf_biu_ahb_pipe.sv
// usbf_biu_ahb_pipe: pipelined AHB-Lite slave bridge into the USB CSR/FIFO block.
// A transfer is accepted in its address phase. Legal transfers issue one CSR strobe
// and then wait for the CDC-returned ready pulse. Illegal ones get a two-cycle ERROR.
// Optional build macro USBF_BIU_TIMEOUT_EN adds a WAIT-cycle counter. An access that
// stalls for TO_MAX cycles is aborted with ERROR.
// DW must be 32 or 64.
`timescale 1ns/1ps
module usbf_biu_ahb_pipe #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter logic [AW-13:0]  USB_BASE = '0,
  parameter int              TO_W     = 8,
  parameter logic [TO_W-1:0] TO_MAX   = 8'd200
) (
  input  logic            hclk_i,
  input  logic            hrstn_i,
  input  logic            hsel_i,
  input  logic            hwrite_i,
  input  logic [1:0]      htrans_i,
  input  logic [2:0]      hsize_i,
  input  logic [AW-1:0]   haddr_i,
  input  logic [DW-1:0]   hwdata_i,
  input  logic            hready_i,
  output logic            hready_o,
  output logic [1:0]      hresp_o,
  output logic [DW-1:0]   hrdata_o,
  output logic            wt_en_o,
  output logic            rd_en_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wstrb_o,
  input  logic [DW-1:0]   rdata_i,
  input  logic            wt_ready_i,
  input  logic            rd_ready_i
);

  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ERR1  = 3'd3;
  localparam logic [2:0] ERR2  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [AW-1:0] addr_p1;
  logic          write_p1;
  logic [2:0]    size_p1;
  logic [DW-1:0] rdata_p2;
  logic          accept, legal, take, busy, rdy, rd_hit, to_hit;
  logic          unused_bits;

  // Window, size and natural-alignment check for the address phase.
  function automatic logic legal_f(input logic [AW-1:0] a, input logic [2:0] sz);
    logic ok;
    ok = (a[AW-1:12] == USB_BASE) && (sz <= 3'(LB));
    if (sz >= 3'd1 && a[0]) ok = 1'b0;
    if (sz >= 3'd2 && a[1]) ok = 1'b0;
    if (sz >= 3'd3 && a[2]) ok = 1'b0;
    return ok;
  endfunction

  // Byte lanes covered by a legal access of 2**sz bytes starting at lane off.
  function automatic logic [NB-1:0] strb_f(input logic [LB-1:0] off, input logic [2:0] sz);
    logic [NB-1:0] m;
    int            n;
    n = 1 << sz;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i >= int'(off)) && (i < int'(off) + n);
    end
    return m;
  endfunction

  assign unused_bits = htrans_i[0];

  assign accept = hsel_i & hready_i & htrans_i[1];
  assign legal  = legal_f(haddr_i, hsize_i);
  assign busy   = (state == ISSUE) || (state == WAIT);
  assign rdy    = write_p1 ? wt_ready_i : rd_ready_i;
  // A new address phase is only taken when the current data phase ends this cycle.
  assign take   = accept && ((state == IDLE) || (state == ERR2) || (busy && rdy));
  assign rd_hit = busy & ~write_p1 & rd_ready_i;

`ifdef USBF_BIU_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_MAX - TO_W'(1);
  logic [TO_W-1:0] to_cnt;

  // Count WAIT cycles of the outstanding access; restarted on entry to ISSUE.
  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i) begin
      to_cnt <= '0;
    end else if (take && legal) begin
      to_cnt <= '0;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign to_hit = (state == WAIT) && (to_cnt == TO_LAST);
`else
  assign to_hit = 1'b0;
`endif

  // Next state: data-phase progress first, then an overlapping accept overrides.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR2: state_nxt = IDLE;
      ISSUE:      state_nxt = rdy ? IDLE : WAIT;
      WAIT: begin
        if (rdy)         state_nxt = IDLE;
        else if (to_hit) state_nxt = ERR1;
        else             state_nxt = WAIT;
      end
      ERR1:       state_nxt = ERR2;
      default:    state_nxt = IDLE;
    endcase
    if (take) state_nxt = legal ? ISSUE : ERR1;
  end

  // State register.
  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Address-phase capture (stage p1) on every taken transfer.
  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i) begin
      addr_p1  <= '0;
      write_p1 <= 1'b0;
      size_p1  <= 3'd0;
    end else if (take) begin
      addr_p1  <= haddr_i;
      write_p1 <= hwrite_i;
      size_p1  <= hsize_i;
    end
  end

  // Read-data hold register (stage p2): refreshed only by a read's own ready.
  always_ff @(posedge hclk_i or negedge hrstn_i) begin
    if (!hrstn_i)    rdata_p2 <= '0;
    else if (rd_hit) rdata_p2 <= rdata_i;
  end

  assign hready_o = busy ? rdy : (state != ERR1);
  assign hresp_o  = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
  assign wt_en_o  = (state == ISSUE) & write_p1;
  assign rd_en_o  = (state == ISSUE) & ~write_p1;
  assign addr_o   = addr_p1;
  assign wdata_o  = hwdata_i;
  assign wstrb_o  = wt_en_o ? strb_f(addr_p1[LB-1:0], size_p1) : '0;
  assign hrdata_o = rd_hit ? rdata_i : rdata_p2;

endmodule
